// File: rtl/keydata_pkg.sv
// Shared types and constants for the keypad data bank: FSM state encoding,
// a constant-evaluable clog2, and the default parameter values.
package keydata_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTRY  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  localparam int DEFAULT_DIGIT_W  = 4;
  localparam int DEFAULT_NDIGITS  = 4;
  localparam int DEFAULT_NCH      = 4;
  localparam int DEFAULT_BCD_ONLY = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/keydata_chreg.sv
// One channel holding register with load enable and asynchronous active-low
// reset; the bank instantiates one of these per channel.
module keydata_chreg #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/keydata_bank.sv
// Keypad entry buffer: digits shift into an edit register, which can be
// committed to one of NCH channel registers; channels also have a direct load port.
module keydata_bank
  import keydata_pkg::*;
#(
  parameter int DIGIT_W  = DEFAULT_DIGIT_W,
  parameter int NDIGITS  = DEFAULT_NDIGITS,
  parameter int NCH      = DEFAULT_NCH,
  parameter int BCD_ONLY = DEFAULT_BCD_ONLY,
  localparam int W       = DIGIT_W * NDIGITS,
  localparam int CH_W    = (clog2(NCH) > 1) ? clog2(NCH) : 1,
  localparam int CNT_W   = clog2(NDIGITS + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [DIGIT_W-1:0] din_i,
  input  logic               keyValid_i,
  input  logic               backspace_i,
  input  logic               clear_i,
  input  logic               commit_i,
  input  logic [CH_W-1:0]    chSel_i,
  input  logic               ldEn_i,
  input  logic [CH_W-1:0]    ldCh_i,
  input  logic [W-1:0]       ldData_i,
  output logic [NCH*W-1:0]   dout_o,
  output logic [W-1:0]       edit_o,
  output logic [CNT_W-1:0]   digitCnt_o,
  output logic               overflow_o,
  output logic               commitAck_o
);

  state_e           state_q, state_d;
  logic [W-1:0]     edit_q, edit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             ack_q, ack_d;
  logic             commitWr;
  logic             digitBad;

  assign digitBad = (BCD_ONLY != 0) && (32'(din_i) > 32'd9);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      edit_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      edit_q  <= edit_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      ack_q   <= ack_d;
    end
  end

  // Only the highest-priority edit input acts: Clear > Commit > Backspace > key.
  always_comb begin
    state_d  = state_q;
    edit_d   = edit_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    ack_d    = 1'b0;
    commitWr = 1'b0;
    case (state_q)
      COMMIT: begin
        state_d = IDLE;
        edit_d  = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end
      default: begin
        if (clear_i) begin
          state_d = IDLE;
          edit_d  = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else if (commit_i) begin
          commitWr = 1'b1;
          ack_d    = 1'b1;
          state_d  = COMMIT;
        end else if (backspace_i) begin
          if (cnt_q != '0) begin
            edit_d  = edit_q >> DIGIT_W;
            cnt_d   = cnt_q - CNT_W'(1);
            state_d = (cnt_q == CNT_W'(1)) ? IDLE : ENTRY;
          end
        end else if (keyValid_i && !digitBad) begin
          if (cnt_q == CNT_W'(NDIGITS)) begin
            ovf_d = 1'b1;
          end else begin
            edit_d  = {edit_q[W-DIGIT_W-1:0], din_i};
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = ENTRY;
          end
        end
      end
    endcase
  end

  // A commit to the same channel as a direct load takes precedence.
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    localparam logic [CH_W-1:0] IDX = CH_W'(k);
    logic hitCommit, hitLoad;
    assign hitCommit = commitWr && (chSel_i == IDX);
    assign hitLoad   = ldEn_i && (ldCh_i == IDX);
    keydata_chreg #(.W(W)) u_chreg (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (hitCommit | hitLoad),
      .d_i    (hitCommit ? edit_q : ldData_i),
      .q_o    (dout_o[k*W +: W])
    );
  end

  assign edit_o      = edit_q;
  assign digitCnt_o  = cnt_q;
  assign overflow_o  = ovf_q;
  assign commitAck_o = ack_q;

endmodule

// File: tb/tb_keydata_bank.sv
// Bench for keydata_bank: directed scenarios followed by random traffic, all
// checked against a digit-list model of the entry buffer and channel bank.
module tb_keydata_bank;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [3:0]  din_i = '0;
  logic        keyValid_i = 1'b0;
  logic        backspace_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        commit_i = 1'b0;
  logic [1:0]  chSel_i = '0;
  logic        ldEn_i = 1'b0;
  logic [1:0]  ldCh_i = '0;
  logic [15:0] ldData_i = '0;
  logic [63:0] dout_o;
  logic [15:0] edit_o;
  logic [2:0]  digitCnt_o;
  logic        overflow_o;
  logic        commitAck_o;

  int total = 0;
  int bad = 0;

  int          digits[$];
  bit          mOvf;
  bit          mAck;
  bit          mInCommit;
  logic [15:0] mCh[4];

  keydata_bank dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .din_i       (din_i),
    .keyValid_i  (keyValid_i),
    .backspace_i (backspace_i),
    .clear_i     (clear_i),
    .commit_i    (commit_i),
    .chSel_i     (chSel_i),
    .ldEn_i      (ldEn_i),
    .ldCh_i      (ldCh_i),
    .ldData_i    (ldData_i),
    .dout_o      (dout_o),
    .edit_o      (edit_o),
    .digitCnt_o  (digitCnt_o),
    .overflow_o  (overflow_o),
    .commitAck_o (commitAck_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [15:0] editValue();
    int v = 0;
    foreach (digits[i]) v = v * 16 + digits[i];
    return v[15:0];
  endfunction

  task automatic modelReset();
    digits.delete();
    mOvf = 0;
    mAck = 0;
    mInCommit = 0;
    foreach (mCh[k]) mCh[k] = '0;
  endtask

  // One clock edge of the model, using the inputs currently on the pins.
  task automatic modelEdge();
    logic [15:0] ev;
    ev = editValue();
    if (ldEn_i) mCh[ldCh_i] = ldData_i;
    if (mInCommit) begin
      digits.delete();
      mOvf = 0;
      mAck = 0;
      mInCommit = 0;
    end else begin
      mAck = 0;
      if (clear_i) begin
        digits.delete();
        mOvf = 0;
      end else if (commit_i) begin
        mCh[chSel_i] = ev;
        mAck = 1;
        mInCommit = 1;
      end else if (backspace_i) begin
        if (digits.size() > 0) void'(digits.pop_back());
      end else if (keyValid_i && din_i <= 9) begin
        if (digits.size() == 4) mOvf = 1;
        else digits.push_back(int'(din_i));
      end
    end
  endtask

  task automatic applyStimulus(input bit key, input int din, input bit bk,
                               input bit clr, input bit cm, input int sel,
                               input bit ld, input int ldch, input logic [15:0] lddata);
    keyValid_i  = key;
    din_i       = din[3:0];
    backspace_i = bk;
    clear_i     = clr;
    commit_i    = cm;
    chSel_i     = sel[1:0];
    ldEn_i      = ld;
    ldCh_i      = ldch[1:0];
    ldData_i    = lddata;
  endtask

  task automatic idleInputs();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
  endtask

  task automatic checkOutput(input string tag);
    logic [15:0] expEdit;
    logic [63:0] expDout;
    expEdit = editValue();
    for (int k = 0; k < 4; k++) expDout[k*16 +: 16] = mCh[k];
    total++;
    assert (edit_o === expEdit) else begin
      bad++;
      $error("[TB] FAIL %s edit got=%h exp=%h", tag, edit_o, expEdit);
    end
    total++;
    assert (digitCnt_o === 3'(digits.size())) else begin
      bad++;
      $error("[TB] FAIL %s digitCnt got=%0d exp=%0d", tag, digitCnt_o, digits.size());
    end
    total++;
    assert (overflow_o === mOvf) else begin
      bad++;
      $error("[TB] FAIL %s overflow got=%b exp=%b", tag, overflow_o, mOvf);
    end
    total++;
    assert (commitAck_o === mAck) else begin
      bad++;
      $error("[TB] FAIL %s commitAck got=%b exp=%b", tag, commitAck_o, mAck);
    end
    total++;
    assert (dout_o === expDout) else begin
      bad++;
      $error("[TB] FAIL %s dout got=%h exp=%h", tag, dout_o, expDout);
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk_i);
    modelEdge();
    #1;
    checkOutput(tag);
    idleInputs();
  endtask

  task automatic key(input int d, input string tag);
    applyStimulus(1, d, 0, 0, 0, 0, 0, 0, 16'h0);
    cycle(tag);
  endtask

  initial begin
    modelReset();
    #1;
    checkOutput("reset_async");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Four keys, commit to channel 2, then cleanup cycle.
    key(1, "k1"); key(2, "k2"); key(3, "k3"); key(4, "k4");
    applyStimulus(0, 0, 0, 0, 1, 2, 0, 0, 16'h0);
    cycle("commit_ch2");
    total++;
    assert (dout_o[47:32] === 16'h1234) else begin
      bad++;
      $error("[TB] FAIL ch2_value got=%h exp=%h", dout_o[47:32], 16'h1234);
    end
    cycle("commit_cleanup");

    // Overflow on a fifth digit, then Clear.
    key(5, "k5"); key(6, "k6"); key(7, "k7"); key(8, "k8"); key(9, "k9_ovf");
    total++;
    assert (edit_o === 16'h5678 && overflow_o === 1'b1) else begin
      bad++;
      $error("[TB] FAIL ovf_value got=%h/%b exp=5678/1", edit_o, overflow_o);
    end
    applyStimulus(1, 3, 1, 1, 1, 0, 0, 0, 16'h0);
    cycle("clear_priority");

    // Backspace behaviour including the empty case.
    key(1, "b1"); key(2, "b2"); key(3, "b3");
    applyStimulus(1, 5, 1, 0, 0, 0, 0, 0, 16'h0);
    cycle("backspace");
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 16'h0); cycle("bs1");
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 16'h0); cycle("bs2");
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 16'h0); cycle("bs_empty");

    // Non-BCD digit is ignored.
    key(7, "pre_hex");
    key(10, "hex_ignored");
    applyStimulus(1, 15, 0, 1, 0, 0, 0, 0, 16'h0);
    cycle("clear_after_hex");

    // Load versus commit on the same and on different channels.
    key(4, "l4"); key(2, "l2");
    applyStimulus(0, 0, 0, 0, 1, 1, 1, 1, 16'hBEEF);
    cycle("ld_same_ch");
    applyStimulus(1, 9, 0, 0, 0, 0, 1, 3, 16'hCAFE);
    cycle("ld_during_commit");
    key(4, "m4"); key(2, "m2");
    applyStimulus(0, 0, 0, 0, 1, 1, 1, 0, 16'hBEEF);
    cycle("ld_diff_ch");
    total++;
    assert (dout_o[15:0] === 16'hBEEF && dout_o[31:16] === 16'h0042) else begin
      bad++;
      $error("[TB] FAIL ld_commit_split got=%h/%h exp=beef/0042", dout_o[15:0], dout_o[31:16]);
    end

    // Reset pulsed in the middle of a COMMIT cycle.
    applyStimulus(1, 6, 0, 0, 0, 0, 0, 0, 16'h0); cycle("r6");
    applyStimulus(0, 0, 0, 0, 1, 3, 0, 0, 16'h0);
    cycle("commit_before_reset");
    #2;
    rst_ni = 1'b0;
    #1;
    modelReset();
    checkOutput("reset_mid_commit");
    applyStimulus(1, 5, 0, 0, 1, 2, 1, 2, 16'h1111);
    @(posedge clk_i);
    #1;
    checkOutput("held_in_reset");
    #2;
    rst_ni = 1'b1;
    applyStimulus(1, 7, 0, 0, 0, 0, 0, 0, 16'h0);
    cycle("first_edge_after_reset");

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      applyStimulus($urandom_range(0, 9) < 6, $urandom_range(0, 15),
                    $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 9) == 0, $urandom_range(0, 3),
                    $urandom_range(0, 7) == 0, $urandom_range(0, 3),
                    16'($urandom));
      cycle("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keydata_bank.md
KEYDATA_BANK -- requirements
Module: keydata_bank

Interface
REQ-001 Parameter DIGIT_W, default 4, bits per keypad digit.
REQ-002 Parameter NDIGITS, default 4, digits per value; W = DIGIT_W*NDIGITS (16 by default).
REQ-003 Parameter NCH, default 4, number of channel registers; CH_W = max(1, clog2(NCH)).
REQ-004 Parameter BCD_ONLY, default 1, when 1 digits above 9 are rejected.
REQ-005 Clock  input  1  single clock, all state changes on rising edge.
REQ-006 Reset  input  1  asynchronous, active-low reset.
REQ-007 Din  input  DIGIT_W  keypad digit, valid when KeyValid=1.
REQ-008 KeyValid  input  1  one-cycle digit strobe.
REQ-009 Backspace  input  1  remove most recently entered digit.
REQ-010 Clear  input  1  discard edit value.
REQ-011 Commit  input  1  request write of edit value to channel ChSel.
REQ-012 ChSel  input  CH_W  target channel for Commit.
REQ-013 LdEN / LdCh / LdData  input  1 / CH_W / W  direct channel load port.
REQ-014 Dout  output  NCH*W  all channel registers, channel k at bits [k*W +: W].
REQ-015 Edit  output  W  edit (shift) register.
REQ-016 DigitCnt  output  clog2(NDIGITS+1)  digits currently in Edit.
REQ-017 Overflow  output  1  sticky, digit dropped because Edit full.
REQ-018 CommitAck  output  1  one-cycle pulse, channel written.

Function
REQ-019 FSM states IDLE (DigitCnt=0), ENTRY (DigitCnt>0), COMMIT (one-cycle write/cleanup); COMMIT always returns to IDLE.
REQ-020 Input priority in IDLE/ENTRY per edge: Clear > Commit > Backspace > KeyValid; only the highest asserted acts.
REQ-021 Accepted key: Edit <= {Edit[W-DIGIT_W-1:0], Din}, DigitCnt+1, state ENTRY.
REQ-022 Key with DigitCnt=NDIGITS: Edit/DigitCnt unchanged, Overflow <= 1.
REQ-023 BCD_ONLY=1 and Din>9: key ignored, no Overflow.
REQ-024 Backspace: Edit <= Edit >> DIGIT_W (zero fill), DigitCnt-1, to IDLE on reaching 0; no-op at DigitCnt=0.
REQ-025 Clear: Edit, DigitCnt, Overflow <= 0, state IDLE.
REQ-026 Commit sampled at edge N: channel[ChSel] <= Edit, CommitAck <= 1, state COMMIT (Dout latency 1 cycle, zero value allowed).
REQ-027 Edge N+1 (COMMIT): Edit, DigitCnt, Overflow <= 0, CommitAck <= 0, state IDLE; all edit inputs ignored this cycle.
REQ-028 ChSel >= NCH: no channel written, CommitAck still pulses.
REQ-029 LdEN=1: channel[LdCh] <= LdData next edge, in any state; LdCh >= NCH ignored.
REQ-030 LdEN and Commit writing same channel on same edge: Commit value wins; different channels both written.
REQ-031 Channel registers hold value when not written.

Reset
REQ-032 Reset=0 immediately (no clock) forces: all channels 0, Edit 0, DigitCnt 0, Overflow 0, CommitAck 0, state IDLE.
REQ-033 Reset asserted during COMMIT aborts it; after release block is in IDLE with all zero.
REQ-034 First edge after Reset rises acts on inputs normally.

Structure
REQ-035 Package keydata_pkg holds state enum (IDLE, ENTRY, COMMIT), clog2 helper, default parameter constants.
REQ-036 Sub-module keydata_chreg (W-bit register, load enable, async active-low reset) instantiated NCH times.

Verification
REQ-037 Keys 1,2,3,4 then Commit ChSel=2 -> CommitAck one cycle, Dout[47:32]=16'h1234, Edit=0 next cycle.
REQ-038 Keys 5,6,7,8,9 -> Edit=16'h5678, DigitCnt=4, Overflow=1; Clear -> Overflow=0, Edit=0.
REQ-039 Keys 1,2,3, Backspace -> Edit=16'h0012, DigitCnt=2; Backspace at DigitCnt=0 -> no change.
REQ-040 Key Din=4'hA with BCD_ONLY=1 -> Edit, DigitCnt, Overflow unchanged.
REQ-041 LdEN=1 LdCh=1 LdData=16'hBEEF with Commit ChSel=1 Edit=16'h0042 -> channel1=16'h0042; LdCh=0 instead -> channel0=16'hBEEF and channel1=16'h0042.
REQ-042 Reset pulsed low mid-cycle during COMMIT -> all outputs 0 asynchronously, channel untouched by later edge, IDLE after release.
